// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the 32 x 32-bit register file.
// Two producers (ALU result path A, load return path M) share the single
// register-file write port. One winner per cycle is chosen round-robin and
// its write is presented one cycle later on registered regWrite/writeReg/
// writeData. A per-register busy bit lets the issue stage stall on operands
// whose write-back has not yet committed.
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  // ALU write-back request
  input  logic          a_valid,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  // load write-back request
  input  logic          m_valid,
  input  logic [AW-1:0] m_reg,
  input  logic [DW-1:0] m_data,
  output logic          m_ready,
  // destination reservation from the issue stage
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_reg,
  // operand busy lookup
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          rs_busy,
  output logic          rt_busy,
  // register-file write port
  output logic          regWrite,
  output logic [AW-1:0] writeReg,
  output logic [DW-1:0] writeData
);

  // Round-robin history: 0 = A was granted last, 1 = M was granted last.
  logic          last_reg;
  logic          last_next;

  logic          grant_a;
  logic          grant_m;
  logic          accept;
  logic [AW-1:0] sel_reg;
  logic [DW-1:0] sel_data;

  logic          reg_write_reg;
  logic [AW-1:0] write_idx_reg;
  logic [DW-1:0] write_data_reg;

  // Write actually committed by the register file at the coming edge.
  logic          commit;

  logic [NREG-1:0] busy;

  // Grant selection: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (!rst) begin
      if (a_valid && (!m_valid || last_reg)) begin
        grant_a = 1'b1;
      end else if (m_valid) begin
        grant_m = 1'b1;
      end
    end
  end

  assign a_ready  = grant_a;
  assign m_ready  = grant_m;
  assign accept   = grant_a | grant_m;
  assign sel_reg  = grant_a ? a_reg  : m_reg;
  assign sel_data = grant_a ? a_data : m_data;

  // Round-robin pointer moves only when somebody is granted.
  always_comb begin
    last_next = last_reg;
    if (grant_a) begin
      last_next = 1'b0;
    end else if (grant_m) begin
      last_next = 1'b1;
    end
  end

  // Arbiter state and registered write port; index/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg       <= 1'b1;
      reg_write_reg  <= 1'b0;
      write_idx_reg  <= '0;
      write_data_reg <= '0;
    end else begin
      last_reg <= last_next;
      if (accept) begin
        write_idx_reg  <= sel_reg;
        write_data_reg <= sel_data;
        reg_write_reg  <= (sel_reg != '0);
      end else begin
        reg_write_reg  <= 1'b0;
      end
    end
  end

  // A write in flight when reset arrives must not land in the register file
  // at the reset edge, so the enable is masked by reset as well.
  assign commit    = reg_write_reg & ~rst;
  assign regWrite  = commit;
  assign writeReg  = write_idx_reg;
  assign writeData = write_data_reg;

  // Scoreboard: one flop per architectural register, register 0 never busy.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy[gi] = 1'b0;
      end else begin : g_bit
        logic bit_reg;
        logic set_hit;
        logic clr_hit;

        assign set_hit = rsv_valid && (rsv_reg == AW'(gi));
        assign clr_hit = commit && (write_idx_reg == AW'(gi));

        // A new reservation on the retiring edge overrides the clear.
        always_ff @(posedge clk) begin
          if (rst) begin
            bit_reg <= 1'b0;
          end else if (set_hit) begin
            bit_reg <= 1'b1;
          end else if (clr_hit) begin
            bit_reg <= 1'b0;
          end
        end

        assign busy[gi] = bit_reg;
      end
    end
  endgenerate

  assign rs_busy = busy[rs];
  assign rt_busy = busy[rt];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of the write-back arbiter against a simple
// register-file sink and a behavioural reference model.
module tb_regfile_wb_arbiter;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, m_valid, rsv_valid;
  logic [AW-1:0] a_reg, m_reg, rsv_reg, rs, rt;
  logic [DW-1:0] a_data, m_data;
  logic          a_ready, m_ready, rs_busy, rt_busy;
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;

  int tests = 0;
  int fails = 0;

  // Register file fed by the DUT write port (not reset, like the real array).
  logic [DW-1:0] rf [NREG] = '{default: '0};
  always @(posedge clk) begin
    if (regWrite) rf[writeReg] <= writeData;
  end

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_reg(m_reg), .m_data(m_data), .m_ready(m_ready),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_reg = 0; a_data = 0;
    m_valid = 0; m_reg = 0; m_data = 0;
    rsv_valid = 0; rsv_reg = 0; rs = 0; rt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    a_valid = 1; a_reg = 7; m_valid = 1; m_reg = 8;
    tick();
    tick();
    #1;
    tests++;
    if (a_ready !== 1'b0 || m_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: a_ready=%b m_ready=%b required 0 0", a_ready, m_ready);
    end
    idle_inputs();
    rst = 0;
    rs = 5; rt = 9;
    #1;
    tests++;
    if (regWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0) begin
      fails++; $display("FAIL reset_port: regWrite=%b writeReg=%0d writeData=%h required 0 0 0", regWrite, writeReg, writeData);
    end
    tests++;
    if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: rs_busy=%b rt_busy=%b required 0 0", rs_busy, rt_busy);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    do_reset();
    a_valid = 1; a_reg = 5; a_data = 32'h1234;
    #1;
    tests++;
    if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
      fails++; $display("FAIL single_grant: a_ready=%b m_ready=%b required 1 0", a_ready, m_ready);
    end
    tick();
    a_valid = 0;
    #1;
    tests++;
    if (regWrite !== 1'b1 || writeReg !== 5'd5 || writeData !== 32'h1234) begin
      fails++; $display("FAIL single_write: regWrite=%b writeReg=%0d writeData=%h required 1 5 00001234", regWrite, writeReg, writeData);
    end
    tick();
    tests++;
    if (regWrite !== 1'b0 || writeReg !== 5'd5) begin
      fails++; $display("FAIL single_after: regWrite=%b writeReg=%0d required 0 5", regWrite, writeReg);
    end
    tests++;
    if (rf[5] !== 32'h1234) begin
      fails++; $display("FAIL single_commit: rf[5]=%h required 00001234", rf[5]);
    end
    $display("[TB] single A write to r5 checked");
  endtask

  task automatic test_contention();
    do_reset();
    a_valid = 1; a_reg = 3; a_data = 32'hA3;
    m_valid = 1; m_reg = 4; m_data = 32'hB4;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (a_ready !== (i % 2 == 0) || m_ready !== (i % 2 == 1)) begin
        fails++; $display("FAIL contention_grant%0d: a_ready=%b m_ready=%b required %b %b", i, a_ready, m_ready, (i % 2 == 0), (i % 2 == 1));
      end
      if (i > 0) begin
        tests++;
        if (regWrite !== 1'b1 || writeReg !== ((i % 2 == 1) ? 5'd3 : 5'd4)) begin
          fails++; $display("FAIL contention_wr%0d: regWrite=%b writeReg=%0d required 1 %0d", i, regWrite, writeReg, (i % 2 == 1) ? 3 : 4);
        end
      end
      tick();
    end
    a_valid = 0; m_valid = 0;
    #1;
    tests++;
    if (regWrite !== 1'b1 || writeReg !== 5'd4 || writeData !== 32'hB4) begin
      fails++; $display("FAIL contention_last: regWrite=%b writeReg=%0d writeData=%h required 1 4 000000b4", regWrite, writeReg, writeData);
    end
    tick();
    tests++;
    if (rf[3] !== 32'hA3 || rf[4] !== 32'hB4) begin
      fails++; $display("FAIL contention_rf: rf3=%h rf4=%h required a3 b4", rf[3], rf[4]);
    end
    $display("[TB] contention A,M,A,M checked");
  endtask

  task automatic test_reg_zero();
    m_valid = 1; m_reg = 0; m_data = 32'hFFFF_FFFF;
    #1;
    tests++;
    if (m_ready !== 1'b1) begin
      fails++; $display("FAIL zero_ready: m_ready=%b required 1", m_ready);
    end
    tick();
    m_valid = 0;
    #1;
    tests++;
    if (regWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL zero_port: regWrite=%b writeReg=%0d writeData=%h required 0 0 ffffffff", regWrite, writeReg, writeData);
    end
    tick();
    tests++;
    if (rf[0] !== 32'd0) begin
      fails++; $display("FAIL zero_rf: rf0=%h required 0", rf[0]);
    end
    $display("[TB] write to r0 checked");
  endtask

  task automatic test_scoreboard();
    do_reset();
    rsv_valid = 1; rsv_reg = 17; rs = 17; rt = 17;
    #1;
    tests++;
    if (rs_busy !== 1'b0) begin
      fails++; $display("FAIL sb_nobypass: rs_busy=%b required 0", rs_busy);
    end
    tick();
    rsv_valid = 0;
    #1;
    tests++;
    if (rs_busy !== 1'b1 || rt_busy !== 1'b1) begin
      fails++; $display("FAIL sb_set: rs_busy=%b rt_busy=%b required 1 1", rs_busy, rt_busy);
    end
    a_valid = 1; a_reg = 17; a_data = 32'h17;
    tick();
    a_valid = 0;
    #1;
    tests++;
    if (regWrite !== 1'b1 || rs_busy !== 1'b1) begin
      fails++; $display("FAIL sb_pending: regWrite=%b rs_busy=%b required 1 1", regWrite, rs_busy);
    end
    tick();
    tests++;
    if (rs_busy !== 1'b0 || rf[17] !== 32'h17) begin
      fails++; $display("FAIL sb_clear: rs_busy=%b rf17=%h required 0 00000017", rs_busy, rf[17]);
    end
    rsv_valid = 1; rsv_reg = 17;
    tick();
    rsv_valid = 0;
    a_valid = 1; a_reg = 17; a_data = 32'h1717;
    tick();
    a_valid = 0;
    rsv_valid = 1; rsv_reg = 17;
    tick();
    rsv_valid = 0;
    #1;
    tests++;
    if (rs_busy !== 1'b1 || rf[17] !== 32'h1717) begin
      fails++; $display("FAIL sb_setwins: rs_busy=%b rf17=%h required 1 00001717", rs_busy, rf[17]);
    end
    $display("[TB] scoreboard set/clear/override checked");
  endtask

  task automatic test_reset_midop();
    logic [DW-1:0] old16;
    do_reset();
    old16 = rf[16];
    rsv_valid = 1; rsv_reg = 16;
    tick();
    rsv_reg = 9;
    tick();
    rsv_valid = 0;
    a_valid = 1; a_reg = 16; a_data = old16 ^ 32'hDEAD_BEEF;
    tick();
    a_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    #1;
    tests++;
    if (regWrite !== 1'b0 || rf[16] !== old16) begin
      fails++; $display("FAIL midrst_drop: regWrite=%b rf16=%h required 0 %h", regWrite, rf[16], old16);
    end
    for (int r = 0; r < NREG; r++) begin
      rs = AW'(r); rt = AW'(NREG - 1 - r);
      #1;
      tests++;
      if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
        fails++; $display("FAIL midrst_busy%0d: rs_busy=%b rt_busy=%b required 0 0", r, rs_busy, rt_busy);
      end
    end
    $display("[TB] reset during in-flight write checked");
  endtask

  task automatic test_random();
    logic [DW-1:0]   ref_rf [NREG];
    logic            ml;
    logic [NREG-1:0] mbusy, nb;
    logic            pend_v;
    logic [AW-1:0]   pend_r;
    logic            ga, gm, a_hold, m_hold;
    int              a_wait, m_wait;
    int              errs;
    do_reset();
    for (int r = 0; r < NREG; r++) ref_rf[r] = rf[r];
    ml = 1; mbusy = '0; pend_v = 0; pend_r = 0;
    a_hold = 0; m_hold = 0; a_wait = 0; m_wait = 0; errs = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!a_hold) begin
        a_valid = ($urandom_range(0, 1) == 1);
        a_reg = AW'($urandom_range(0, NREG - 1)); a_data = $urandom;
      end
      if (!m_hold) begin
        m_valid = ($urandom_range(0, 1) == 1);
        m_reg = AW'($urandom_range(0, NREG - 1)); m_data = $urandom;
      end
      rsv_valid = ($urandom_range(0, 9) < 3);
      rsv_reg = AW'($urandom_range(0, NREG - 1));
      rs = AW'($urandom_range(0, NREG - 1));
      rt = AW'($urandom_range(0, NREG - 1));
      #1;
      ga = a_valid && (!m_valid || ml);
      gm = m_valid && !ga;
      tests++;
      if (a_ready !== ga || m_ready !== gm || rs_busy !== mbusy[rs] || rt_busy !== mbusy[rt]) begin
        fails++; errs++;
        if (errs <= 5) $display("FAIL rand_c%0d: a_ready=%b m_ready=%b rs_busy=%b rt_busy=%b required %b %b %b %b", c, a_ready, m_ready, rs_busy, rt_busy, ga, gm, mbusy[rs], mbusy[rt]);
      end
      tests++;
      if (a_ready === 1'b1 && m_ready === 1'b1) begin
        fails++; $display("FAIL rand_both_c%0d: a_ready=1 m_ready=1 required at most one", c);
      end
      a_wait = (a_valid && a_ready !== 1'b1) ? a_wait + 1 : 0;
      m_wait = (m_valid && m_ready !== 1'b1) ? m_wait + 1 : 0;
      tests++;
      if (a_wait > 1 || m_wait > 1) begin
        fails++; $display("FAIL rand_starve_c%0d: a_wait=%0d m_wait=%0d required <=1", c, a_wait, m_wait);
      end
      a_hold = a_valid && a_ready !== 1'b1;
      m_hold = m_valid && m_ready !== 1'b1;
      // Reference next state.
      nb = mbusy;
      if (pend_v) nb[pend_r] = 1'b0;
      if (rsv_valid && rsv_reg != 0) nb[rsv_reg] = 1'b1;
      pend_v = 0;
      if (ga) begin
        ml = 0;
        if (a_reg != 0) begin ref_rf[a_reg] = a_data; pend_v = 1; pend_r = a_reg; end
      end else if (gm) begin
        ml = 1;
        if (m_reg != 0) begin ref_rf[m_reg] = m_data; pend_v = 1; pend_r = m_reg; end
      end
      tick();
      mbusy = nb;
    end
    idle_inputs();
    tick();
    tick();
    for (int r = 0; r < NREG; r++) begin
      tests++;
      if (rf[r] !== ref_rf[r]) begin
        fails++; $display("FAIL rand_rf%0d: rf=%h required %h", r, rf[r], ref_rf[r]);
      end
    end
    $display("[TB] random traffic 10000 cycles checked");
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_single();
    test_contention();
    test_reg_zero();
    test_scoreboard();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
